// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array: symbol codes, controller
// states and default scoring parameters.
package sw_pkg;

    localparam int SYM_W = 3;
    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t SYM_NULL = 3'd0;
    localparam sym_t SYM_A    = 3'd1;
    localparam sym_t SYM_C    = 3'd2;
    localparam sym_t SYM_G    = 3'd3;
    localparam sym_t SYM_T    = 3'd4;
    localparam sym_t NULL_CH  = SYM_NULL;

    localparam int DEF_ALPHA = 2;
    localparam int DEF_BETA  = 1;
    localparam int DEF_N     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/sw_len_cnt.sv
// Loadable down-counter shared by every phase of the controller; tc marks the
// final cycle of a phase (count == 1).
module sw_len_cnt #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - LEN_W'(1);
        end
    end

    assign tc = (count == LEN_W'(1));

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for one Smith-Waterman PE chain: loads the padded query, streams
// the target with init held, drains the pipeline and captures the final score.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int   NUM_PE  = 16,
    parameter int   LEN_W   = 10,
    parameter int   N       = 16,
    parameter sym_t NULL_CH = sw_pkg::NULL_CH
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] s_len_i,
    input  logic [LEN_W-1:0] t_len_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  sym_t             s_data_i,
    input  logic             t_valid_i,
    output logic             t_ready_o,
    input  sym_t             t_data_i,
    output logic             shift_valid_s_o,
    output logic             valid_s_o,
    output sym_t             s_o,
    output sym_t             t_o,
    output logic             init_o,
    input  logic [N-1:0]     max_last_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N-1:0]     score_o,
    output logic             err_o
);

    localparam logic [LEN_W-1:0] LOAD_CYC  = LEN_W'(NUM_PE);
    localparam logic [LEN_W-1:0] DRAIN_CYC = LEN_W'(NUM_PE + 2);
    localparam logic [LEN_W-1:0] FLUSH_CYC = LEN_W'(NUM_PE + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] s_len_q, t_len_q;
    logic             dirty_q, dirty_d;
    logic             pend_q, pend_d;
    logic             latch_len;
    logic             cnt_load, cnt_dec, cnt_tc;
    logic [LEN_W-1:0] cnt_val, cnt;
    logic             len_ok;

    logic             s_ready_d, t_ready_d, shift_d, valid_s_d, init_d;
    logic             busy_d, done_d, err_d;
    sym_t             s_d, t_d;
    logic [N-1:0]     score_d;

    sw_len_cnt #(.LEN_W(LEN_W)) u_cnt (
        .clk      (clk),
        .reset_i  (reset_i),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    assign len_ok = (s_len_i != '0) && (s_len_i <= LOAD_CYC) && (t_len_i != '0);

    always_comb begin
        // NOTE: every signal gets a value before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        dirty_d   = dirty_q;
        pend_d    = pend_q;
        latch_len = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        s_ready_d = 1'b0;
        t_ready_d = 1'b0;
        shift_d   = 1'b0;
        valid_s_d = 1'b0;
        s_d       = NULL_CH;
        t_d       = NULL_CH;
        init_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        score_d   = score_o;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !len_ok) begin
                    err_d = 1'b1;
                end else if (start_i) begin
                    latch_len = 1'b1;
                    cnt_load  = 1'b1;
                    if (dirty_q) begin
                        // Array state is unknown after reset: clear it before loading.
                        state_d = ST_FLUSH;
                        cnt_val = FLUSH_CYC;
                        pend_d  = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        cnt_val   = LOAD_CYC;
                        s_ready_d = (s_len_i == LOAD_CYC);
                    end
                end
            end

            ST_LOAD: begin
                if (s_ready_o && !s_valid_i) begin
                    s_ready_d = s_ready_o;
                    shift_d   = shift_valid_s_o;
                    valid_s_d = valid_s_o;
                    s_d       = s_o;
                end else begin
                    shift_d   = 1'b1;
                    valid_s_d = 1'b1;
                    s_d       = s_ready_o ? s_data_i : NULL_CH;
                    if (cnt_tc) begin
                        state_d   = ST_STREAM;
                        cnt_load  = 1'b1;
                        cnt_val   = t_len_q;
                        t_ready_d = 1'b1;
                    end else begin
                        cnt_dec   = 1'b1;
                        s_ready_d = ((cnt - LEN_W'(1)) <= s_len_q);
                    end
                end
            end

            ST_STREAM: begin
                if (t_valid_i) begin
                    init_d = 1'b1;
                    t_d    = t_data_i;
                    if (cnt_tc) begin
                        state_d  = ST_DRAIN;
                        cnt_load = 1'b1;
                        cnt_val  = DRAIN_CYC;
                    end else begin
                        cnt_dec   = 1'b1;
                        t_ready_d = 1'b1;
                    end
                end else begin
                    err_d    = 1'b1;
                    state_d  = ST_FLUSH;
                    cnt_load = 1'b1;
                    cnt_val  = FLUSH_CYC;
                end
            end

            ST_DRAIN: begin
                init_d = 1'b1;
                if (cnt_tc) begin
                    score_d  = max_last_i;
                    done_d   = 1'b1;
                    state_d  = ST_FLUSH;
                    cnt_load = 1'b1;
                    cnt_val  = FLUSH_CYC;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (cnt_tc) begin
                    dirty_d = 1'b0;
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        state_d   = ST_LOAD;
                        cnt_load  = 1'b1;
                        cnt_val   = LOAD_CYC;
                        s_ready_d = (s_len_q == LOAD_CYC);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            s_len_q         <= '0;
            t_len_q         <= '0;
            dirty_q         <= 1'b1;
            pend_q          <= 1'b0;
            s_ready_o       <= 1'b0;
            t_ready_o       <= 1'b0;
            shift_valid_s_o <= 1'b0;
            valid_s_o       <= 1'b0;
            s_o             <= '0;
            t_o             <= '0;
            init_o          <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            score_o         <= '0;
            err_o           <= 1'b0;
        end else begin
            state_q         <= state_d;
            dirty_q         <= dirty_d;
            pend_q          <= pend_d;
            if (latch_len) begin
                s_len_q <= s_len_i;
                t_len_q <= t_len_i;
            end
            s_ready_o       <= s_ready_d;
            t_ready_o       <= t_ready_d;
            shift_valid_s_o <= shift_d;
            valid_s_o       <= valid_s_d;
            s_o             <= s_d;
            t_o             <= t_d;
            init_o          <= init_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            score_o         <= score_d;
            err_o           <= err_d;
        end
    end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with a 4-PE chain; max_last_i carries the
// edge index in its upper byte so the captured score also proves capture timing.
module tb_sw_array_ctrl;
    import sw_pkg::*;

    localparam int NUM_PE = 4;
    localparam int LEN_W  = 10;
    localparam int N      = 16;

    logic             clk = 1'b0;
    logic             reset_i, start_i;
    logic [LEN_W-1:0] s_len_i, t_len_i;
    logic             s_valid_i, s_ready_o, t_valid_i, t_ready_o;
    sym_t             s_data_i, t_data_i, s_o, t_o;
    logic             shift_valid_s_o, valid_s_o, init_o;
    logic [N-1:0]     max_last_i, score_o;
    logic             busy_o, done_o, err_o;

    int checks = 0;
    int failures = 0;

    sym_t q_acgt[4];
    sym_t q_gt[4];
    sym_t t_acgt[4];

    int lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done;

    sw_array_ctrl #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .N(N), .NULL_CH(SYM_NULL)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .s_len_i         (s_len_i),
        .t_len_i         (t_len_i),
        .s_valid_i       (s_valid_i),
        .s_ready_o       (s_ready_o),
        .s_data_i        (s_data_i),
        .t_valid_i       (t_valid_i),
        .t_ready_o       (t_ready_o),
        .t_data_i        (t_data_i),
        .shift_valid_s_o (shift_valid_s_o),
        .valid_s_o       (valid_s_o),
        .s_o             (s_o),
        .t_o             (t_o),
        .init_o          (init_o),
        .max_last_i      (max_last_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .score_o         (score_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] out_vec();
        return {s_ready_o, t_ready_o, shift_valid_s_o, valid_s_o, s_o, t_o,
                init_o, busy_o, done_o, err_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one job from start until busy_o drops; edge 0 is the edge that samples start_i.
    task automatic run_job(input int sl, input int tl, input sym_t sq[4], input sym_t tq[4],
                           input int stall_beat, input int stall_cycles, input int drop_beat,
                           input logic [7:0] ref_sc,
                           output int o_lat, output int o_tail, output int o_err, output int o_pad,
                           output int o_data, output int o_bad, output int o_frozen, output int o_done);
        int k = 0;
        int s_idx = 0;
        int t_idx = 0;
        int stall_left = stall_cycles;
        int done_k = -1;
        logic pre_sr, pre_tr;
        logic [13:0] snap;
        o_lat = -1; o_tail = -1; o_err = 0; o_pad = 0; o_data = 0; o_bad = 0; o_frozen = 0; o_done = 0;
        start_i    = 1'b1;
        s_len_i    = LEN_W'(sl);
        t_len_i    = LEN_W'(tl);
        s_valid_i  = 1'b0;
        t_valid_i  = 1'b0;
        max_last_i = {8'd0, ref_sc};
        tick();
        start_i = 1'b0;
        while (busy_o && k < 300) begin
            k++;
            s_data_i   = (s_idx < sl) ? sq[s_idx] : SYM_NULL;
            s_valid_i  = !(s_idx == stall_beat && stall_left > 0);
            t_data_i   = (t_idx < tl) ? tq[t_idx] : SYM_NULL;
            t_valid_i  = (t_idx != drop_beat);
            max_last_i = {k[7:0], ref_sc};
            pre_sr = s_ready_o;
            pre_tr = t_ready_o;
            snap   = out_vec();
            tick();
            if (pre_sr && s_valid_i) begin
                if (!shift_valid_s_o || s_o !== sq[s_idx]) o_bad++;
                o_data++;
                s_idx++;
            end else if (pre_sr) begin
                stall_left--;
                if (out_vec() === snap) o_frozen++;
            end else if (shift_valid_s_o && s_o == SYM_NULL) begin
                o_pad++;
            end
            if (pre_tr && t_valid_i) t_idx++;
            if (err_o) o_err++;
            if (done_o) begin
                o_done++;
                o_lat  = k + 1;
                done_k = k;
            end
        end
        if (done_k >= 0) o_tail = k - done_k;
        if (busy_o) o_lat = -2;
        s_valid_i = 1'b0;
        t_valid_i = 1'b0;
    endtask

    initial begin
        int w;
        q_acgt = '{SYM_T, SYM_G, SYM_C, SYM_A};
        q_gt   = '{SYM_T, SYM_G, SYM_NULL, SYM_NULL};
        t_acgt = '{SYM_A, SYM_C, SYM_G, SYM_T};
        reset_i = 1'b1; start_i = 1'b0; s_len_i = '0; t_len_i = '0;
        s_valid_i = 1'b0; t_valid_i = 1'b0; s_data_i = SYM_NULL; t_data_i = SYM_NULL;
        max_last_i = '0;
        tick();
        tick();
        check("reset_outputs", 32'(out_vec()), 32'd0);
        check("reset_score", 32'(score_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // First job after reset: flush of NUM_PE+1 cycles precedes LOAD.
        run_job(4, 4, q_acgt, t_acgt, -1, 0, -1, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("a_latency", 32'(lat), 32'd20);
        check("a_score", 32'(score_o), 32'h1308);
        check("a_busy_tail", 32'(busy_tail), 32'd5);
        check("a_data_beats", 32'(n_data), 32'd4);
        check("a_data_order", 32'(n_bad), 32'd0);
        check("a_pad", 32'(n_pad), 32'd0);
        check("a_err", 32'(n_err), 32'd0);

        // Clean array: start to done is 1 + NUM_PE + t_len + NUM_PE + 2.
        run_job(4, 4, q_acgt, t_acgt, -1, 0, -1, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("b_latency", 32'(lat), 32'd15);
        check("b_score", 32'(score_o), 32'h0E08);
        check("b_done_pulses", 32'(n_done), 32'd1);
        check("b_done_low", 32'(done_o), 32'd0);

        // Short query: two NULL pad shifts, then two query beats.
        run_job(2, 4, q_gt, t_acgt, -1, 0, -1, 8'd4, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("c_pad", 32'(n_pad), 32'd2);
        check("c_data_beats", 32'(n_data), 32'd2);
        check("c_data_order", 32'(n_bad), 32'd0);
        check("c_latency", 32'(lat), 32'd15);
        check("c_score", 32'(score_o), 32'h0E04);

        // Query stall of 3 cycles on the second character.
        run_job(4, 4, q_acgt, t_acgt, 1, 3, -1, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("d_frozen", 32'(n_frozen), 32'd3);
        check("d_latency", 32'(lat), 32'd18);
        check("d_score", 32'(score_o), 32'h1108);
        check("d_data_order", 32'(n_bad), 32'd0);

        // Target stream gap at beat 2 aborts the job.
        run_job(4, 4, q_acgt, t_acgt, -1, 0, 2, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("e_err", 32'(n_err), 32'd1);
        check("e_no_done", 32'(n_done), 32'd0);
        check("e_busy_low", 32'(busy_o), 32'd0);
        check("e_score_kept", 32'(score_o), 32'h1108);

        // Illegal lengths: s_len=0, s_len=NUM_PE+1, t_len=0.
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1;
            s_len_i = (i == 0) ? LEN_W'(0) : (i == 1) ? LEN_W'(5) : LEN_W'(4);
            t_len_i = (i == 2) ? LEN_W'(0) : LEN_W'(4);
            tick();
            start_i = 1'b0;
            check($sformatf("f%0d_err", i), 32'(err_o), 32'd1);
            check($sformatf("f%0d_busy", i), 32'(busy_o), 32'd0);
            tick();
            check($sformatf("f%0d_err_pulse", i), 32'(err_o), 32'd0);
            check($sformatf("f%0d_idle", i), 32'(busy_o), 32'd0);
        end

        // Start and reset together: reset wins.
        start_i = 1'b1; reset_i = 1'b1; s_len_i = LEN_W'(4); t_len_i = LEN_W'(4);
        tick();
        start_i = 1'b0; reset_i = 1'b0;
        check("g_reset_wins", 32'(out_vec()), 32'd0);
        tick();
        check("g_still_idle", 32'(busy_o), 32'd0);

        // Flush the dirty array with one job, then reset in the middle of STREAM.
        run_job(4, 4, q_acgt, t_acgt, -1, 0, -1, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("h_latency", 32'(lat), 32'd20);
        start_i = 1'b1; s_len_i = LEN_W'(4); t_len_i = LEN_W'(4);
        s_data_i = SYM_A; s_valid_i = 1'b1;
        tick();
        start_i = 1'b0;
        w = 0;
        while (!t_ready_o && w < 40) begin
            tick();
            w++;
        end
        check("h_reach_stream", 32'(t_ready_o), 32'd1);
        t_valid_i = 1'b1; t_data_i = SYM_C;
        tick();
        check("h_in_stream", 32'(init_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0; s_valid_i = 1'b0; t_valid_i = 1'b0;
        check("h_reset_outputs", 32'(out_vec()), 32'd0);
        check("h_reset_score", 32'(score_o), 32'd0);

        // Job after mid-job reset runs the flush again and scores correctly.
        run_job(4, 4, q_acgt, t_acgt, -1, 0, -1, 8'd8, lat, busy_tail, n_err, n_pad, n_data, n_bad, n_frozen, n_done);
        check("i_latency", 32'(lat), 32'd20);
        check("i_score", 32'(score_o), 32'h1308);
        check("i_err", 32'(n_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
